conv_par_ser: RTL

Parametrised single-clock wide-to-narrow width converter. It accepts IN_W-bit words on a valid/ready handshake and emits them as RATIO = IN_W/OUT_W consecutive OUT_W-bit slices on a second valid/ready handshake. It replaces the fixed 32→8 two-clock converter in the PHY data path with these additions:

- backpressure on both sides;
- per-word selectable slice order;
- an end-of-word marker;
- gapless back-to-back throughput, so no clk_f/clk_4f pair is needed.

---
 rtl/conv_par_ser.sv | 95 +++++++++
 1 files changed

// File: rtl/conv_par_ser.sv
// Wide-to-narrow width converter: accepts IN_W-bit words and emits them as
// RATIO consecutive OUT_W-bit slices, with backpressure on both sides.
module conv_par_ser #(
    parameter int IN_W = 32,
    parameter int OUT_W = 8,
    localparam int RATIO = IN_W / OUT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_msb_first,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    if ((RATIO < 2) || (IN_W != RATIO * OUT_W)) begin : g_param_check
        $error("conv_par_ser: IN_W must be a multiple of OUT_W with RATIO >= 2");
    end

    logic [IN_W-1:0]  sreg_r, sreg_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ord_r, ord_s;
    logic             busy_r, busy_s;
    logic             last_s, acc_s, iss_s;

    // The slice at the output end of the shift register for the latched order.
    function automatic logic [OUT_W-1:0] pick_slice(input logic [IN_W-1:0] word,
                                                    input logic msb_first);
        logic [OUT_W-1:0] slice;
        if (msb_first) begin
            slice = word[IN_W-1 -: OUT_W];
        end else begin
            slice = word[OUT_W-1:0];
        end
        return slice;
    endfunction

    // Output decode straight from state; in_ready also sees out_ready so a new
    // word can load on the same edge the last slice leaves.
    always_comb begin
        last_s    = busy_r & (cnt_r == LAST_CNT);
        out_valid = busy_r;
        out_last  = last_s;
        out_data  = pick_slice(sreg_r, ord_r);
        in_ready  = ~busy_r | (last_s & out_ready);
        acc_s     = in_valid & in_ready;
        iss_s     = busy_r & out_ready;
    end

    // Next-state: load wins over the last-slice issue; otherwise step or empty.
    always_comb begin
        sreg_s = sreg_r;
        cnt_s  = cnt_r;
        ord_s  = ord_r;
        busy_s = busy_r;
        if (acc_s) begin
            sreg_s = in_data;
            ord_s  = in_msb_first;
            cnt_s  = {CNT_W{1'b0}};
            busy_s = 1'b1;
        end else if (iss_s) begin
            if (last_s) begin
                busy_s = 1'b0;
            end else begin
                cnt_s  = cnt_r + CNT_W'(1);
                sreg_s = ord_r ? (sreg_r << OUT_W) : (sreg_r >> OUT_W);
            end
        end else begin
            busy_s = busy_r;
        end
    end

    // State register; reset drops any partially sent word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg_r <= {IN_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            ord_r  <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            sreg_r <= sreg_s;
            cnt_r  <= cnt_s;
            ord_r  <= ord_s;
            busy_r <= busy_s;
        end
    end

endmodule
